// File: rtl/cron_pkg.sv
// Shared definitions for the stopwatch core: FSM state encoding and width.
package cron_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    SET   = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cron_state_t;
endpackage

// File: rtl/cronometro_ctrl_if.sv
// Control/status bundle between the stopwatch core and its user (buttons, display path).
interface cronometro_ctrl_if #(parameter int WIDTH = 14);
  import cron_pkg::*;

  logic                runner;
  logic                modo;
  logic                clear;
  logic                lap;
  logic [WIDTH-1:0]    limite;
  logic [WIDTH-1:0]    num_at;
  logic [WIDTH-1:0]    lap_val;
  logic                lap_vld;
  logic                done;
  logic                done_p;
  logic [STATE_W-1:0]  state;

  modport master (
    output runner, modo, clear, lap, limite,
    input  num_at, lap_val, lap_vld, done, done_p, state
  );

  modport slave (
    input  runner, modo, clear, lap, limite,
    output num_at, lap_val, lap_vld, done, done_p, state
  );
endinterface

// File: rtl/cronometro_ctrl_tick_gen.sv
// Prescaler: counts enabled clk cycles and flags every PRESCALE-th one; no derived clocks.
module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pcnt;

  assign tick = en && (pcnt == LAST);

  // clr wins over en so SET/DONE always restart a full period
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             pcnt <= '0;
    else if (clr)          pcnt <= '0;
    else if (en)           pcnt <= (pcnt == LAST) ? '0 : pcnt + 1'b1;
  end
endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch/timer core: up/down count at a prescaled rate with pause, lap capture and completion.
module cronometro_ctrl
  import cron_pkg::*;
#(
  parameter int WIDTH       = 14,
  parameter int PRESCALE    = 50_000_000,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  cronometro_ctrl_if.slave  bus
);
  cron_state_t      st;
  logic [WIDTH-1:0] num_at, target, start, lap_val;
  logic             modo_q, lap_vld, done, done_p;
  logic             tick, en, clr, mode_chg;

  assign mode_chg = (bus.modo != modo_q);
  // Prescaler advances only on cycles that could actually step, so pauses lose nothing
  assign en  = (st == RUN) && bus.runner && !bus.clear && !mode_chg;
  assign clr = (st == SET) || (st == DONE);

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= SET;
      num_at  <= '0;
      target  <= '0;
      start   <= '0;
      modo_q  <= 1'b0;
      lap_val <= '0;
      lap_vld <= 1'b0;
      done    <= 1'b0;
      done_p  <= 1'b0;
    end else begin
      done_p <= 1'b0;
      if (st != SET && bus.lap) begin
        lap_val <= num_at;
        lap_vld <= 1'b1;
      end
      if (st == SET) begin
        num_at  <= bus.modo ? bus.limite : '0;
        start   <= bus.modo ? bus.limite : '0;
        target  <= bus.modo ? '0 : bus.limite;
        modo_q  <= bus.modo;
        lap_vld <= 1'b0;
        done    <= 1'b0;
        if (bus.runner && !bus.clear) st <= RUN;
      end else if (bus.clear || mode_chg) begin
        st   <= SET;
        done <= 1'b0;
      end else begin
        case (st)
          RUN: begin
            if (!bus.runner) begin
              st <= PAUSE;
            end else if (num_at == target) begin
              st     <= DONE;
              done   <= 1'b1;
              done_p <= 1'b1;
            end else if (tick) begin
              num_at <= modo_q ? num_at - 1'b1 : num_at + 1'b1;
            end
          end
          PAUSE: if (bus.runner) st <= RUN;
          DONE: begin
            if (AUTO_RELOAD && bus.runner) begin
              num_at <= start;
              st     <= RUN;
              done   <= 1'b0;
            end
          end
          default: st <= SET;
        endcase
      end
    end
  end

  assign bus.num_at  = num_at;
  assign bus.lap_val = lap_val;
  assign bus.lap_vld = lap_vld;
  assign bus.done    = done;
  assign bus.done_p  = done_p;
  assign bus.state   = st;
endmodule

// File: tb/tb_cronometro_ctrl.sv
// Randomised + directed bench: three cores (P=4, P=4 auto-reload, P=1) share stimulus, scoreboarded per cycle.
module tb_cronometro_ctrl;
  localparam int W = 14;
  localparam int N = 3;
  localparam int S_SET = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  typedef struct packed {
    logic [W-1:0] num;
    logic [W-1:0] lapv;
    logic         lapq;
    logic         done;
    logic         dp;
    logic [1:0]   st;
  } obs_t;

  typedef struct {
    int st;
    int cnt, tgt, start, lapv, acc;
    bit mq, lapq, done, dp;
  } mdl_t;

  logic clk = 1'b0, reset = 1'b1;
  logic runner = 0, modo = 0, clear = 0, lap = 0;
  logic [W-1:0] limite = '0;

  int checks = 0, failures = 0;
  obs_t act [N];
  obs_t exp_q [N][$];
  mdl_t m [N];

  always #5 clk = ~clk;

  cronometro_ctrl_if #(.WIDTH(W)) bus [N] ();

  for (genvar g = 0; g < N; g++) begin : gd
    cronometro_ctrl #(.WIDTH(W), .PRESCALE(g == 2 ? 1 : 4), .AUTO_RELOAD(g == 1 ? 1'b1 : 1'b0)) dut (
      .clk(clk), .reset(reset), .bus(bus[g])
    );
    assign bus[g].runner = runner;
    assign bus[g].modo   = modo;
    assign bus[g].clear  = clear;
    assign bus[g].lap    = lap;
    assign bus[g].limite = limite;
    assign act[g] = {bus[g].num_at, bus[g].lap_val, bus[g].lap_vld, bus[g].done, bus[g].done_p, bus[g].state};
  end

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '{st: S_SET, cnt: 0, tgt: 0, start: 0, lapv: 0, acc: 0, mq: 0, lapq: 0, done: 0, dp: 0};
    return r;
  endfunction

  // Reference: count steps once every P accumulated active run cycles.
  function automatic mdl_t mdl_step(input mdl_t mi, input int p, input bit ar);
    mdl_t r = mi;
    r.dp = 0;
    if (r.st != S_SET && lap) begin r.lapv = r.cnt; r.lapq = 1; end
    if (r.st == S_SET) begin
      r.mq = modo; r.start = modo ? int'(limite) : 0; r.cnt = r.start;
      r.tgt = modo ? 0 : int'(limite); r.lapq = 0; r.acc = 0; r.done = 0;
      if (runner && !clear) r.st = S_RUN;
    end else if (clear || modo != r.mq) begin
      r.st = S_SET; r.done = 0;
    end else if (r.st == S_PAUSE) begin
      if (runner) r.st = S_RUN;
    end else if (r.st == S_DONE) begin
      r.acc = 0;
      if (ar && runner) begin r.cnt = r.start; r.st = S_RUN; r.done = 0; end
    end else if (!runner) begin
      r.st = S_PAUSE;
    end else if (r.cnt == r.tgt) begin
      r.st = S_DONE; r.done = 1; r.dp = 1; r.acc = 0;
    end else begin
      r.acc++;
      if (r.acc == p) begin r.acc = 0; r.cnt += r.mq ? -1 : 1; end
    end
    return r;
  endfunction

  function automatic obs_t to_obs(input mdl_t r);
    obs_t o;
    o = {W'(r.cnt), W'(r.lapv), r.lapq, r.done, r.dp, 2'(r.st)};
    return o;
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (reset) m[g] = mdl_reset();
      else       m[g] = mdl_step(m[g], (g == 2) ? 1 : 4, g == 1);
      exp_q[g].push_back(to_obs(m[g]));
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (exp_q[g].size() > 0) begin
        obs_t e;
        e = exp_q[g].pop_front();
        checks++;
        if (act[g] !== e) begin
          failures++;
          $display("FAIL sb dut%0d t=%0t act num=%0d lap=%0d/%0b done=%0b dp=%0b st=%0d req num=%0d lap=%0d/%0b done=%0b dp=%0b st=%0d",
                   g, $time, act[g].num, act[g].lapv, act[g].lapq, act[g].done, act[g].dp, act[g].st,
                   e.num, e.lapv, e.lapq, e.done, e.dp, e.st);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string name, input int a, input int r);
    checks++;
    if (a != r) begin
      failures++;
      $display("FAIL %s act=%0d req=%0d", name, a, r);
    end
  endtask

  task automatic wait_num(input int v, input int budget);
    int n = 0;
    while (int'(act[0].num) != v && n < budget) begin cyc(1); n++; end
    chk("wait_num", int'(act[0].num), v);
  endtask

  task automatic restart(input logic md, input int lim);
    runner = 0; clear = 1; cyc(1);
    clear = 0; modo = md; limite = W'(lim); cyc(1);
    runner = 1;
  endtask

  initial begin
    cyc(3);
    chk("reset_state", int'(act[0].st), S_SET);
    reset = 0;
    cyc(1);

    // Up count 0..5
    restart(0, 5); cyc(40);
    chk("up_hold", int'(act[0].num), 5);
    chk("up_done", int'(act[0].done), 1);

    // Down count with pause at 7
    restart(1, 10); wait_num(7, 100);
    runner = 0; cyc(20);
    chk("pause_hold", int'(act[0].num), 7);
    runner = 1; cyc(40);
    chk("down_end", int'(act[0].num), 0);

    // Lap at 3, then mode change back to SET
    restart(0, 10); wait_num(3, 100);
    lap = 1; cyc(1); lap = 0; cyc(1);
    chk("lap_val", int'(act[0].lapv), 3);
    chk("lap_vld", int'(act[0].lapq), 1);
    cyc(5); modo = 1; cyc(3);
    chk("mode_set_lapvld", int'(act[0].lapq), 0);
    chk("mode_reload", int'(act[0].num), 10);

    // Zero limit completes without a tick
    restart(0, 0); cyc(4);
    chk("zero_done", int'(act[0].done), 1);

    // Auto-reload down from 3
    restart(1, 3); cyc(60);

    // clear and runner together: SET wins
    clear = 1; cyc(1);
    chk("clear_wins", int'(act[0].st), S_SET);
    clear = 0;

    // Async reset between edges mid-count
    restart(0, 9); cyc(7);
    @(posedge clk); #2 reset = 1;
    for (int g = 0; g < N; g++) exp_q[g].delete();
    #1;
    for (int g = 0; g < N; g++) chk("async_reset", int'(act[g]), 0);
    cyc(2); reset = 0; cyc(1);

    // Full-scale up count on the P=1 core: stops at 16383, no wrap
    restart(0, 16383); cyc(16400);
    chk("max_num", int'(act[2].num), 16383);
    chk("max_done", int'(act[2].done), 1);

    // Random phase
    restart(0, 6);
    for (int i = 0; i < 3000; i++) begin
      runner = ($urandom_range(0, 9) != 0);
      lap    = ($urandom_range(0, 7) == 0);
      clear  = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 99) == 0) modo = ~modo;
      if ($urandom_range(0, 15) == 0) limite = W'($urandom_range(0, 20));
      cyc(1);
    end
    runner = 0; lap = 0; clear = 0;
    cyc(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
